// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// ---------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_reducer
//
// Final reduction stage of an 8x8 unsigned multiplier built from a
// half-adder array. The array leaves four partial-product rows, each a
// sum/pass vector t (9 bits) and a carry vector b (7 bits). Row i is
// worth (t_i + (b_i << 2)) << (2*i). This block registers one row set per
// handshake, accumulates ROWS_PER_CYCLE rows per clock into a 17-bit
// accumulator and presents the sum clamped to 16 bits.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                synchronous active-low reset
//   ha_array_<i>_b[6:0]  carry vector of row i (i = 0..3)
//   ha_array_<i>_t[8:0]  sum/pass vector of row i (i = 0..3)
//   in_valid / in_ready  input row-set handshake
//   product[15:0]        min(sum, 65535), zero unless out_valid
//   sat                  1 when the sum exceeded 65535
//   out_valid/out_ready  output handshake
//   fsm_state[1:0]       current FSM state (0 IDLE, 1 ACC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data until that edge; the block
// holds product/sat/out_valid stable while out_valid=1 and out_ready=0.
// In DONE in_ready follows out_ready, so a new set can be accepted on the
// same edge that the result is consumed.
// ---------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_reducer #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] product,
  output logic        sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  fsm_state
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  t_q [4];
  logic [6:0]  b_q [4];
  logic [16:0] acc, acc_nxt, acc_sum;
  // Three bits so the counter can reach 4, which marks "all rows added".
  logic [2:0]  cnt, cnt_nxt;
  logic [16:0] row_val [4];
  logic        take;

  assign take      = in_valid & in_ready;
  assign fsm_state = state;

  // Weighted value of each registered row; b sits two columns above t.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      row_val[i] = ({8'd0, t_q[i]} + {8'd0, b_q[i], 2'b00}) << (2 * i);
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    acc_sum   = acc;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ACC: begin
        // cnt is always a multiple of ROWS_PER_CYCLE, so cnt + j stays in 0..3.
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
          acc_sum = acc_sum + row_val[2'(cnt[1:0] + 2'(j))];
        end
        acc_nxt = acc_sum;
        cnt_nxt = cnt + 3'(ROWS_PER_CYCLE);
        if (cnt_nxt == 3'd4) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_nxt = ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        t_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        t_q[0] <= ha_array_0_t;
        t_q[1] <= ha_array_1_t;
        t_q[2] <= ha_array_2_t;
        t_q[3] <= ha_array_3_t;
        b_q[0] <= ha_array_0_b;
        b_q[1] <= ha_array_1_b;
        b_q[2] <= ha_array_2_b;
        b_q[3] <= ha_array_3_b;
      end
    end
  end

  // Outputs decode straight from state and acc; reset clears both, so the
  // outputs are zero right after a reset edge.
  always_comb begin
    out_valid = (state == DONE);
    sat       = (state == DONE) && acc[16];
    product   = '0;
    if (state == DONE) begin
      product = acc[16] ? 16'hFFFF : acc[15:0];
    end
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_array_reducer.md
UNSIGNED_MUL_8X8_HA_ARRAY_REDUCER -- requirements
Module: unsigned_mul_8x8_ha_array_reducer

Interface
REQ-001 The block SHALL have parameter ROWS_PER_CYCLE, default 1, giving the number of half-adder rows accumulated per cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have inputs ha_array_0_b..ha_array_3_b, 7 bits each, the carry vector of each partial-product row.
REQ-005 The block SHALL have inputs ha_array_0_t..ha_array_3_t, 9 bits each, the sum/pass vector of each partial-product row.
REQ-006 The block SHALL have input in_valid, 1 bit, meaning the eight row vectors are valid.
REQ-007 The block SHALL have output in_ready, 1 bit, meaning the block can accept a row set.
REQ-008 The block SHALL have output product, 16 bits, the reduced unsigned product.
REQ-009 The block SHALL have output sat, 1 bit, meaning product was clamped.
REQ-010 The block SHALL have output out_valid, 1 bit, meaning product and sat are valid.
REQ-011 The block SHALL have input out_ready, 1 bit, the downstream accept.

Function
REQ-012 Row i (i=0..3) SHALL contribute value_i = (t_i + (b_i << 2)) << (2*i): t_i[k] weighs 2^(2i+k) and b_i[k] weighs 2^(2i+k+2).
REQ-013 The input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; all eight vectors are registered at that edge, and later input changes have no effect until the next handshake.
REQ-014 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-015 IDLE SHALL hold in_ready=1 and out_valid=0; on a handshake it clears the 17-bit accumulator and the row counter and moves to ACC.
REQ-016 ACC SHALL hold in_ready=0 and out_valid=0.
REQ-017 Each ACC cycle SHALL add ROWS_PER_CYCLE row values, indexed by the row counter, to the accumulator and advance the counter by ROWS_PER_CYCLE.
REQ-018 ACC SHALL move to DONE on the edge that adds row 3.
REQ-019 The accumulator SHALL be 17 bits and never wraps, since the maximum sum is 86615.
REQ-020 In DONE, product SHALL equal min(acc, 65535).
REQ-021 In DONE, sat SHALL be 1 exactly when acc > 65535, and out_valid SHALL be 1.
REQ-022 Latency SHALL be 4/ROWS_PER_CYCLE + 1 rising edges from the input handshake to the first edge at which out_valid=1 is sampled (5 cycles for ROWS_PER_CYCLE=1).
REQ-023 DONE SHALL hold product, sat and out_valid stable until out_ready=1.
REQ-024 In DONE, in_ready SHALL equal out_ready.
REQ-025 If DONE sees out_ready=1 and in_valid=1 on the same edge, the result SHALL be consumed and the new set accepted, going directly to ACC (back-to-back, no IDLE cycle).
REQ-026 If DONE sees out_ready=1 and in_valid=0, the block SHALL return to IDLE.
REQ-027 In IDLE and ACC, product and sat SHALL be 0.
REQ-028 Any ROWS_PER_CYCLE other than 1, 2 or 4 SHALL be rejected at elaboration.

Reset
REQ-029 While rst_n=0 at a rising edge, the state SHALL go to IDLE and the accumulator, row counter, product, sat and out_valid SHALL go to 0.
REQ-030 After that reset edge, in_ready SHALL be 1.
REQ-031 Reset asserted in ACC or DONE SHALL abandon the operation with no output handshake produced.
REQ-032 The first set after reset deassertion SHALL be accepted normally.

Verification
REQ-033 All vectors zero, handshake, out_ready=1 -> out_valid high 5 cycles later (ROWS_PER_CYCLE=1), product=0, sat=0.
REQ-034 ha_array_0_t=9'h001, others 0 -> product=1; only ha_array_3_b[6]=1 -> product=16384; only ha_array_2_t[8]=1 -> product=4096.
REQ-035 All t=9'h1FF, all b=7'h7F -> acc=86615, product=65535, sat=1.
REQ-036 out_ready held 0 for 10 cycles in DONE -> product, sat and out_valid stable, in_ready=0; out_ready=1 with in_valid=1 -> next set accepted on the same edge, next result 5 cycles later.
REQ-037 rst_n=0 for one edge during ACC -> out_valid never asserts for that set, in_ready=1 after reset, next set (row0 t=9'h003) -> product=3.
REQ-038 Rerun REQ-033 to REQ-035 with ROWS_PER_CYCLE=2 and 4 -> identical products, latency 3 and 2 cycles.
